// File: rtl/irrigation_cycle_timer_if.sv
// Signal bundle between the cycle timer and its controller: tick, commands and status.
// The master side drives the tick and commands; the slave side is the timer itself.
interface irrigation_cycle_timer_if #(
    parameter int CNT_W = 8
) ();
    logic             tick_in;
    logic             start;
    logic             stop;
    logic             mode;
    logic             valve_on;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] remaining;

    modport master (
        output tick_in, start, stop, mode,
        input  valve_on, busy, done, aborted, remaining
    );

    modport slave (
        input  tick_in, start, stop, mode,
        output valve_on, busy, done, aborted, remaining
    );
endinterface

// File: rtl/irrigation_cycle_timer.sv
// Times one watering cycle: valve open for a mode-selected number of slow ticks, then a
// valve-closed settle interval. The slow tick is synchronized and edge-detected on clk.
module irrigation_cycle_timer #(
    parameter int CNT_W        = 8,
    parameter int DRIP_TICKS   = 60,
    parameter int SPRK_TICKS   = 20,
    parameter int SETTLE_TICKS = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    irrigation_cycle_timer_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WATER  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] L_DRIP   = CNT_W'(DRIP_TICKS);
    localparam logic [CNT_W-1:0] L_SPRK   = CNT_W'(SPRK_TICKS);
    localparam logic [CNT_W-1:0] L_SETTLE = CNT_W'(SETTLE_TICKS);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_tick_prev;
    logic             w_tick_p;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_remaining;
    logic             r_valve;
    logic             r_aborted;
    logic [CNT_W-1:0] w_duration;

    // NOTE: tick_in is asynchronous to clk; two flops resolve metastability before any logic sees it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_tick_prev <= 1'b0;
        end else begin
            r_sync1     <= bus.tick_in;
            r_sync2     <= r_sync1;
            r_tick_prev <= r_sync2;
        end
    end

    assign w_tick_p   = r_sync2 & ~r_tick_prev;
    assign w_duration = bus.mode ? L_SPRK : L_DRIP;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_valve     <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_aborted <= 1'b0;
                        if (w_duration == '0) begin
                            r_state     <= S_SETTLE;
                            r_remaining <= L_SETTLE;
                        end else begin
                            r_state     <= S_WATER;
                            r_valve     <= 1'b1;
                            r_remaining <= w_duration;
                        end
                    end
                end
                S_WATER: begin
                    // Abort has priority over a tick landing on the same edge.
                    if (bus.stop) begin
                        r_state     <= S_SETTLE;
                        r_valve     <= 1'b0;
                        r_aborted   <= 1'b1;
                        r_remaining <= L_SETTLE;
                    end else if (w_tick_p) begin
                        if (r_remaining <= CNT_W'(1)) begin
                            r_state     <= S_SETTLE;
                            r_valve     <= 1'b0;
                            r_remaining <= L_SETTLE;
                        end else begin
                            r_remaining <= r_remaining - CNT_W'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_remaining == '0) begin
                        r_state <= S_DONE;
                    end else if (w_tick_p) begin
                        if (r_remaining == CNT_W'(1)) begin
                            r_state     <= S_DONE;
                            r_remaining <= '0;
                        end else begin
                            r_remaining <= r_remaining - CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_remaining <= '0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_valve     <= 1'b0;
                    r_remaining <= '0;
                end
            endcase
        end
    end

    assign bus.valve_on  = r_valve;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.aborted   = r_aborted;
    assign bus.remaining = r_remaining;

endmodule

// File: tb/tb_irrigation_cycle_timer.sv
// Randomized bench for irrigation_cycle_timer against a tick-counting phase model.
// Ticks are recorded at their rising edge and credited three clk edges later.
module tb_irrigation_cycle_timer;

    localparam int CNT_W  = 8;
    localparam int DRIP   = 5;
    localparam int SPRK   = 3;
    localparam int SETTLE = 2;
    localparam int TICK_P = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    irrigation_cycle_timer_if #(.CNT_W(CNT_W)) ifc ();

    irrigation_cycle_timer #(
        .CNT_W(CNT_W), .DRIP_TICKS(DRIP), .SPRK_TICKS(SPRK), .SETTLE_TICKS(SETTLE)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit due[int];

    typedef enum {P_IDLE, P_WATER, P_SETTLE, P_DONE} phase_e;
    typedef struct {
        phase_e ph;
        int     len;
        int     cnt;
        bit     ab;
    } model_t;

    model_t m = '{P_IDLE, 0, 0, 1'b0};

    // Phase model: counts ticks up within each phase and ends the phase when the count hits its length.
    function automatic model_t step(model_t s, bit start, bit stop, bit mode, bit tick);
        model_t n = s;
        case (s.ph)
            P_IDLE: if (start) begin
                n.ab  = 1'b0;
                n.len = mode ? SPRK : DRIP;
                n.cnt = 0;
                if (n.len == 0) begin
                    n.ph  = P_SETTLE;
                    n.len = SETTLE;
                end else begin
                    n.ph = P_WATER;
                end
            end
            P_WATER: if (stop) begin
                n.ph = P_SETTLE; n.ab = 1'b1; n.len = SETTLE; n.cnt = 0;
            end else if (tick) begin
                n.cnt++;
                if (n.cnt >= n.len) begin
                    n.ph = P_SETTLE; n.len = SETTLE; n.cnt = 0;
                end
            end
            P_SETTLE: if (n.len == 0) begin
                n.ph = P_DONE;
            end else if (tick) begin
                n.cnt++;
                if (n.cnt >= n.len) n.ph = P_DONE;
            end
            P_DONE: n.ph = P_IDLE;
            default: n.ph = P_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [11:0] expv(model_t s);
        logic [7:0] rem;
        rem = (s.ph == P_WATER || s.ph == P_SETTLE) ? 8'(s.len - s.cnt) : 8'd0;
        return {(s.ph == P_WATER), (s.ph != P_IDLE), (s.ph == P_DONE), s.ab, rem};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '{P_IDLE, 0, 0, 1'b0};
        else       m <= step(m, ifc.start, ifc.stop, ifc.mode, due.exists(cyc + 1));
    end

    logic [11:0] obs;
    logic [11:0] want;
    assign obs  = {ifc.valve_on, ifc.busy, ifc.done, ifc.aborted, ifc.remaining};
    assign want = expv(m);

    // Free-running slow tick, changed on negedges; a rise is credited on the third posedge after it.
    initial begin
        int ph;
        ph = int'($urandom_range(0, TICK_P - 1));
        ifc.tick_in = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % TICK_P;
            if (ph == TICK_P / 2) begin
                ifc.tick_in = 1'b1;
                due[cyc + 3] = 1'b1;
            end else if (ph == 0) begin
                ifc.tick_in = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic test_reset();
        ifc.start = 1'b0; ifc.stop = 1'b0; ifc.mode = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs, 12'h000);
        end
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL reset_idle got=%h want=%h", obs, 12'h000);
        end
    endtask

    task automatic test_sprinkler();
        int nd = 0;
        @(negedge clk);
        ifc.mode = 1'b1; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        checks++;
        if ({ifc.valve_on, ifc.busy, ifc.remaining} !== {1'b1, 1'b1, 8'(SPRK)}) begin
            failures++;
            $display("FAIL sprk_start got v=%b b=%b r=%0d want v=1 b=1 r=%0d",
                     ifc.valve_on, ifc.busy, ifc.remaining, SPRK);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL sprk_cycle cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            if (ifc.done) nd++;
            if (m.ph == P_IDLE) break;
        end
        checks++;
        if (nd !== 1 || {ifc.busy, ifc.aborted, ifc.valve_on} !== 3'b000) begin
            failures++;
            $display("FAIL sprk_end done_pulses=%0d busy=%b aborted=%b want 1,0,0", nd, ifc.busy, ifc.aborted);
        end
    endtask

    task automatic test_drip();
        int   seq[$];
        int   exp_seq[$];
        int   water_ticks = 0;
        int   last = -1;
        @(negedge clk);
        ifc.mode = 1'b0; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int k = DRIP; k >= 1; k--) exp_seq.push_back(k);
        for (int k = SETTLE; k >= 1; k--) exp_seq.push_back(k);
        for (int i = 0; i < 400; i++) begin
            if (ifc.busy && ifc.remaining != 0 && int'(ifc.remaining) != last) begin
                seq.push_back(int'(ifc.remaining));
            end
            last = int'(ifc.remaining);
            if (ifc.valve_on && due.exists(cyc + 1)) water_ticks++;
            @(negedge clk);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL drip_cycle cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            if (m.ph == P_IDLE) break;
        end
        checks++;
        if (seq != exp_seq) begin
            failures++;
            $display("FAIL drip_sequence got=%p want=%p", seq, exp_seq);
        end
        checks++;
        if (water_ticks !== DRIP) begin
            failures++;
            $display("FAIL drip_open_ticks got=%0d want=%0d", water_ticks, DRIP);
        end
    endtask

    task automatic test_stop();
        int nd = 0;
        bit hit = 1'b0;
        @(negedge clk);
        ifc.mode = 1'b0; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ifc.valve_on && ifc.remaining == 8'd2) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL stop_wait remaining never reached 2 in water, got r=%0d", ifc.remaining);
        end
        ifc.stop = 1'b1;
        @(negedge clk);
        ifc.stop = 1'b0;
        checks++;
        if ({ifc.valve_on, ifc.aborted, ifc.busy, ifc.remaining} !== {1'b0, 1'b1, 1'b1, 8'(SETTLE)}) begin
            failures++;
            $display("FAIL stop_abort got v=%b a=%b b=%b r=%0d want v=0 a=1 b=1 r=%0d",
                     ifc.valve_on, ifc.aborted, ifc.busy, ifc.remaining, SETTLE);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL stop_cycle cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            if (ifc.done) nd++;
            if (m.ph == P_IDLE) break;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (nd !== 1 || ifc.aborted !== 1'b1 || ifc.busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_sticky done_pulses=%0d aborted=%b busy=%b want 1,1,0", nd, ifc.aborted, ifc.busy);
        end
    endtask

    task automatic test_stop_with_tick();
        int nd = 0;
        bit hit = 1'b0;
        @(negedge clk);
        ifc.mode = 1'b1; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        checks++;
        if (ifc.aborted !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear got=%b want=0", ifc.aborted);
        end
        for (int i = 0; i < 40; i++) begin
            if (ifc.valve_on && due.exists(cyc + 1)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL stoptick_wait no tick found in water, got v=%b", ifc.valve_on);
        end
        ifc.stop = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifc.valve_on, ifc.aborted, ifc.remaining} !== {1'b0, 1'b1, 8'(SETTLE)}) begin
            failures++;
            $display("FAIL stoptick_priority got v=%b a=%b r=%0d want v=0 a=1 r=%0d",
                     ifc.valve_on, ifc.aborted, ifc.remaining, SETTLE);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL stoptick_settle cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            if (ifc.done) nd++;
            if (m.ph == P_IDLE) break;
        end
        ifc.stop = 1'b0;
        checks++;
        if (nd !== 1) begin
            failures++;
            $display("FAIL stoptick_done got=%0d want=1", nd);
        end
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        int water_ticks = 0;
        bit settle_pulsed = 1'b0;
        @(negedge clk);
        ifc.mode = 1'b1; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ifc.valve_on && due.exists(cyc + 1)) water_ticks++;
            ifc.start = 1'b0;
            if (i == 3) ifc.start = 1'b1;
            if (ifc.busy && !ifc.valve_on && !ifc.done && !settle_pulsed) begin
                ifc.start = 1'b1;
                settle_pulsed = 1'b1;
            end
            ifc.mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL b2b_cycle cyc=%0d got=%h want=%h", cyc, obs, want);
            end
            if (ifc.done) nd++;
            if (m.ph == P_IDLE) break;
        end
        ifc.start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (nd !== 1 || water_ticks !== SPRK || ifc.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ignored done=%0d ticks=%0d busy=%b want 1,%0d,0", nd, water_ticks, ifc.busy, SPRK);
        end
    endtask

    task automatic test_reset_mid_cycle();
        @(negedge clk);
        ifc.mode = 1'b0; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (ifc.valve_on !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_open got=%b want=1", ifc.valve_on);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({ifc.valve_on, ifc.busy, ifc.remaining} !== 10'h000) begin
            failures++;
            $display("FAIL rstmid_async got v=%b b=%b r=%0d want 0,0,0", ifc.valve_on, ifc.busy, ifc.remaining);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 12'h000 || obs !== want) begin
                failures++;
                $display("FAIL rstmid_quiet cyc=%0d got=%h want=%h", cyc, obs, want);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int nd = 0;
            int stop_at;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            stop_at = int'($urandom_range(0, 80));
            ifc.mode = 1'($urandom_range(0, 1));
            ifc.start = 1'b1;
            @(negedge clk);
            ifc.start = 1'b0;
            for (int i = 0; i < 400; i++) begin
                ifc.stop  = (i == stop_at);
                ifc.start = ($urandom_range(0, 7) == 0);
                ifc.mode  = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if (obs !== want) begin
                    failures++;
                    $display("FAIL rand_cycle run=%0d cyc=%0d got=%h want=%h", n, cyc, obs, want);
                end
                if (ifc.done) nd++;
                if (m.ph == P_IDLE) break;
            end
            ifc.start = 1'b0;
            ifc.stop  = 1'b0;
            checks++;
            if (nd !== 1 || ifc.busy !== 1'b0) begin
                failures++;
                $display("FAIL rand_end run=%0d done=%0d busy=%b want 1,0", n, nd, ifc.busy);
            end
        end
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        ifc.mode  = 1'b0;
        test_reset();
        test_sprinkler();
        test_drip();
        test_stop();
        test_stop_with_tick();
        test_back_to_back();
        test_reset_mid_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
